// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to restore the sign of finished results.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~operand + WIDTH'(1)) : operand;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, with the sign
// fix applied as the last step completes. Done is reported in the FIX
// cycle so Busy (and therefore Stall) still covers it.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OP_W  = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [OP_W-1:0]  Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state;
    logic [CNT_W-1:0]   iter_cnt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   src_a;
    logic               op_is_div;
    logic               div_zero;
    logic               neg_result;
    logic               neg_rem;
    logic [2*WIDTH-1:0] prod_acc;
    logic [WIDTH-1:0]   part_rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               dbz_reg;

    logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
    logic is_signed, is_arith;

    assign is_mult   = (Op == OP_W'(OP_MULT));
    assign is_multu  = (Op == OP_W'(OP_MULTU));
    assign is_div    = (Op == OP_W'(OP_DIV));
    assign is_divu   = (Op == OP_W'(OP_DIVU));
    assign is_mthi   = (Op == OP_W'(OP_MTHI));
    assign is_mtlo   = (Op == OP_W'(OP_MTLO));
    assign is_signed = is_mult | is_div;
    assign is_arith  = is_mult | is_multu | is_div | is_divu;

    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;

    assign a_neg_in = is_signed & A[WIDTH-1];
    assign b_neg_in = is_signed & B[WIDTH-1];

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
        .operand (A),
        .negate  (a_neg_in),
        .result  (mag_a_in)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
        .operand (B),
        .negate  (b_neg_in),
        .result  (mag_b_in)
    );

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    // One multiply step and one restoring-divide step, computed in parallel.
    always_comb begin
        mul_sum = {1'b0, prod_acc[2*WIDTH-1:WIDTH]};
        if (prod_acc[0]) begin
            mul_sum = mul_sum + {1'b0, mag_a};
        end
        prod_next = {mul_sum, prod_acc[WIDTH-1:1]};

        rem_shift = {part_rem, quo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_b};
        if (!rem_diff[WIDTH]) begin
            rem_next = rem_diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .operand (prod_next),
        .negate  (neg_result),
        .result  (prod_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .operand (quo_next),
        .negate  (neg_result),
        .result  (quo_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .operand (rem_next),
        .negate  (neg_rem),
        .result  (rem_fix)
    );

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Pick the final HI/LO pair; divide-by-zero returns all ones and the raw dividend.
    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (op_is_div) begin
            if (div_zero) begin
                res_hi = src_a;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // Control FSM plus operand, iteration and HI/LO registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            iter_cnt   <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            src_a      <= '0;
            op_is_div  <= 1'b0;
            div_zero   <= 1'b0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
            prod_acc   <= '0;
            part_rem   <= '0;
            quo        <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start && !Flush) begin
                        if (is_arith) begin
                            state      <= ST_RUN;
                            busy_reg   <= 1'b1;
                            iter_cnt   <= CNT_W'(WIDTH);
                            mag_a      <= mag_a_in;
                            mag_b      <= mag_b_in;
                            src_a      <= A;
                            op_is_div  <= is_div | is_divu;
                            div_zero   <= (B == '0);
                            neg_result <= a_neg_in ^ b_neg_in;
                            neg_rem    <= a_neg_in;
                            prod_acc   <= {{WIDTH{1'b0}}, mag_b_in};
                            part_rem   <= '0;
                            quo        <= mag_a_in;
                            dbz_reg    <= 1'b0;
                        end else if (is_mthi) begin
                            hi_reg  <= A;
                            dbz_reg <= 1'b0;
                        end else if (is_mtlo) begin
                            lo_reg  <= A;
                            dbz_reg <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (Flush) begin
                        state    <= ST_IDLE;
                        busy_reg <= 1'b0;
                    end else begin
                        prod_acc <= prod_next;
                        part_rem <= rem_next;
                        quo      <= quo_next;
                        iter_cnt <= iter_cnt - CNT_W'(1);
                        if (iter_cnt == CNT_W'(1)) begin
                            state    <= ST_FIX;
                            hi_reg   <= res_hi;
                            lo_reg   <= res_lo;
                            done_reg <= 1'b1;
                            dbz_reg  <= op_is_div & div_zero;
                        end
                    end
                end
                ST_FIX: begin
                    state    <= ST_IDLE;
                    busy_reg <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_reg;
    assign Done      = done_reg;
    assign Stall     = ReadHiLo & busy_reg;
    assign Hi        = hi_reg;
    assign Lo        = lo_reg;
    assign DivByZero = dbz_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance driven from a vector
// table plus hand-written flush/stall sequences, and an 8-bit instance
// for the narrow-width product and mid-operation reset.
module tb_muldiv_unit;

    localparam logic [2:0] T_MULT  = 3'd0;
    localparam logic [2:0] T_MULTU = 3'd1;
    localparam logic [2:0] T_DIV   = 3'd2;
    localparam logic [2:0] T_DIVU  = 3'd3;
    localparam logic [2:0] T_MTHI  = 3'd4;
    localparam logic [2:0] T_MTLO  = 3'd5;
    localparam logic [2:0] T_RSVD  = 3'd6;
    localparam int NUM_VECS = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, flush, read_hilo;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, stall, dbz;
    logic [31:0] hi, lo;

    logic        reset8, start8, flush8, read_hilo8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, stall8, dbz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32), .OP_W(3)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .Start     (start),
        .Op        (op),
        .A         (a),
        .B         (b),
        .Flush     (flush),
        .ReadHiLo  (read_hilo),
        .Busy      (busy),
        .Done      (done),
        .Stall     (stall),
        .Hi        (hi),
        .Lo        (lo),
        .DivByZero (dbz)
    );

    muldiv_unit #(.WIDTH(8), .OP_W(3)) dut8 (
        .Clk       (clk),
        .Reset     (reset8),
        .Start     (start8),
        .Op        (op8),
        .A         (a8),
        .B         (b8),
        .Flush     (flush8),
        .ReadHiLo  (read_hilo8),
        .Busy      (busy8),
        .Done      (done8),
        .Stall     (stall8),
        .Hi        (hi8),
        .Lo        (lo8),
        .DivByZero (dbz8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs [NUM_VECS];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Launch one arithmetic op on the 32-bit unit; lat counts edges from the sampling edge to Done.
    task automatic applyStimulus(input logic [2:0] op_in, input logic [31:0] a_in, input logic [31:0] b_in,
                                 output int lat);
        @(negedge clk);
        start = 1'b1;
        op    = op_in;
        a     = a_in;
        b     = b_in;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("dbz_cleared_on_start", dbz, 0);
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus8(input logic [2:0] op_in, input logic [7:0] a_in, input logic [7:0] b_in,
                                  output int lat);
        @(negedge clk);
        start8 = 1'b1;
        op8    = op_in;
        a8     = a_in;
        b8     = b_in;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Single-edge request (moves, reserved ops, start+flush) on the 32-bit unit.
    task automatic pulseRequest(input logic [2:0] op_in, input logic [31:0] a_in, input logic with_flush);
        @(negedge clk);
        start = 1'b1;
        flush = with_flush;
        op    = op_in;
        a     = a_in;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        bit done_seen;

        vecs[0]  = '{T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{T_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{T_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{T_DIVU,  32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{T_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[6]  = '{T_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vecs[7]  = '{T_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{T_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{T_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[10] = '{T_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{T_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[12] = '{T_DIV,   32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000002, 1'b0};

        reset = 1'b1; start = 1'b0; flush = 1'b0; read_hilo = 1'b1;
        op = 3'd0; a = '0; b = '0;
        reset8 = 1'b1; start8 = 1'b0; flush8 = 1'b0; read_hilo8 = 1'b0;
        op8 = 3'd0; a8 = '0; b8 = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_dbz", dbz, 0);
        @(negedge clk);
        reset  = 1'b0;
        reset8 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_stall", stall, 0);
        read_hilo = 1'b0;

        $display("[TB] moves and flush");
        pulseRequest(T_MTHI, 32'h5, 1'b0);
        checkOutput("mthi_hi", hi, 32'h5);
        checkOutput("mthi_busy", busy, 0);
        checkOutput("mthi_done", done, 0);
        pulseRequest(T_MTLO, 32'h5, 1'b0);
        checkOutput("mtlo_lo", lo, 32'h5);

        @(negedge clk);
        start = 1'b1; op = T_MULT; a = 32'd3; b = 32'd4;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkOutput("busy_before_flush", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_hi", hi, 32'h5);
        checkOutput("flush_lo", lo, 32'h5);
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        checkOutput("flush_no_done", done_seen, 0);
        checkOutput("flush_lo_later", lo, 32'h5);

        pulseRequest(T_MULT, 32'h0, 1'b1);
        checkOutput("start_flush_busy", busy, 0);
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        checkOutput("start_flush_idle", done_seen, 0);
        pulseRequest(T_MTHI, 32'h9, 1'b1);
        checkOutput("mthi_flush_hi", hi, 32'h5);
        pulseRequest(T_RSVD, 32'h77, 1'b0);
        checkOutput("reserved_busy", busy, 0);
        checkOutput("reserved_hi", hi, 32'h5);
        checkOutput("reserved_lo", lo, 32'h5);

        $display("[TB] vector table");
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("v%0d_latency", i), lat, 33);
            checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            checkOutput($sformatf("v%0d_dbz", i), dbz, vecs[i].exp_dbz);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_done_pulse", i), done, 0);
            checkOutput($sformatf("v%0d_busy_after", i), busy, 0);
        end

        $display("[TB] stall during DIVU 100/7");
        @(negedge clk);
        read_hilo = 1'b1;
        start = 1'b1; op = T_DIVU; a = 32'd100; b = 32'd7;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == 4) begin
                start = 1'b1; op = T_MTHI; a = 32'hDEAD;
            end
            checkOutput($sformatf("stall_edge%0d", k), stall, (k <= 33));
            if (k == 33) begin
                checkOutput("stall_done", done, 1);
                checkOutput("stall_lo", lo, 32'd14);
                checkOutput("stall_hi", hi, 32'd2);
            end
            if (k == 34) begin
                checkOutput("stall_done_fall", done, 0);
                checkOutput("stall_hi_kept", hi, 32'd2);
            end
        end
        read_hilo = 1'b0;

        $display("[TB] WIDTH=8 instance");
        applyStimulus8(T_MULT, 8'h80, 8'h80, lat);
        checkOutput("w8_latency", lat, 9);
        checkOutput("w8_hi", hi8, 8'h40);
        checkOutput("w8_lo", lo8, 8'h00);
        @(posedge clk);
        #1;
        applyStimulus8(T_DIVU, 8'h05, 8'h00, lat);
        checkOutput("w8_dz_hi", hi8, 8'h05);
        checkOutput("w8_dz_lo", lo8, 8'hFF);
        checkOutput("w8_dz_dbz", dbz8, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        start8 = 1'b1; op8 = T_MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        read_hilo8 = 1'b1;
        #1;
        checkOutput("w8_busy_mid", busy8, 1);
        checkOutput("w8_stall_mid", stall8, 1);
        reset8 = 1'b1;
        @(posedge clk);
        #1;
        reset8 = 1'b0;
        checkOutput("w8_rst_busy", busy8, 0);
        checkOutput("w8_rst_done", done8, 0);
        checkOutput("w8_rst_hi", hi8, 0);
        checkOutput("w8_rst_lo", lo8, 0);
        checkOutput("w8_rst_dbz", dbz8, 0);
        checkOutput("w8_rst_stall", stall8, 0);
        done_seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) done_seen = 1'b1;
        end
        checkOutput("w8_rst_no_done", done_seen, 0);
        read_hilo8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
